// File: rtl/enemy_shooter.sv
// Enemy ship controller: horizontal patrol with edge bounce, periodic firing
// from a bullet pool, per-slot bullet advance/expiry and hit-point tracking.
module enemy_shooter #(
  parameter int X_W         = 8,
  parameter int Y_W         = 8,
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int MOVE_DIV    = 12500000,
  parameter int BULLET_DIV  = 6250000,
  parameter int FIRE_PERIOD = 4,
  parameter int NUM_BULLETS = 4,
  parameter int HEALTH_W    = 3,
  parameter int HEALTH_INIT = 3
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       hit,
  input  logic                       respawn,
  output logic [X_W-1:0]             x,
  output logic                       alive,
  output logic [HEALTH_W-1:0]        health,
  output logic [NUM_BULLETS-1:0]     bullet_valid,
  output logic [NUM_BULLETS*X_W-1:0] bullet_x,
  output logic [NUM_BULLETS*Y_W-1:0] bullet_y,
  output logic                       fire,
  output logic                       died
);

  localparam int MC_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int BC_W = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
  localparam int FC_W = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;

  localparam logic [MC_W-1:0]     MOVE_RELOAD = MC_W'(MOVE_DIV - 1);
  localparam logic [BC_W-1:0]     BUL_RELOAD  = BC_W'(BULLET_DIV - 1);
  localparam logic [FC_W-1:0]     FIRE_LAST   = FC_W'(FIRE_PERIOD - 1);
  localparam logic [X_W-1:0]      X_LAST      = X_W'(X_MAX - 1);
  localparam logic [Y_W-1:0]      Y_LAST      = Y_W'(Y_MAX - 1);
  localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(HEALTH_INIT);

  typedef enum logic [1:0] {S_RIGHT, S_LEFT, S_DEAD} state_t;

  state_t                       r_state;
  logic [X_W-1:0]               r_x;
  logic                         r_alive;
  logic [HEALTH_W-1:0]          r_health;
  logic [FC_W-1:0]              r_fireCnt;
  logic                         r_fire;
  logic                         r_died;
  logic [MC_W-1:0]              r_moveCnt;
  logic [BC_W-1:0]              r_bulCnt;
  logic [NUM_BULLETS-1:0]       r_valid;
  logic [NUM_BULLETS*X_W-1:0]   r_bulletX;
  logic [NUM_BULLETS*Y_W-1:0]   r_bulletY;

  logic                         w_moveTick;
  logic                         w_bulletTick;
  logic                         w_living;
  logic                         w_fatal;
  logic                         w_fireAttempt;
  logic                         w_doSpawn;
  logic [NUM_BULLETS-1:0]       w_freeOH;
  logic [X_W-1:0]               w_xNext;
  state_t                       w_dirNext;

  assign x            = r_x;
  assign alive        = r_alive;
  assign health       = r_health;
  assign bullet_valid = r_valid;
  assign bullet_x     = r_bulletX;
  assign bullet_y     = r_bulletY;
  assign fire         = r_fire;
  assign died         = r_died;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_moveCnt <= MOVE_RELOAD;
      r_bulCnt  <= BUL_RELOAD;
    end else if (enable) begin
      r_moveCnt <= (r_moveCnt == '0) ? MOVE_RELOAD : r_moveCnt - MC_W'(1);
      r_bulCnt  <= (r_bulCnt == '0) ? BUL_RELOAD : r_bulCnt - BC_W'(1);
    end
  end

  assign w_moveTick   = enable && (r_moveCnt == '0);
  assign w_bulletTick = enable && (r_bulCnt == '0);

  // Respawn outranks everything in its cycle, including a pending move/fire.
  assign w_living      = (r_state != S_DEAD) && !respawn;
  assign w_fatal       = w_living && hit && (r_health == HEALTH_W'(1));
  assign w_fireAttempt = w_living && w_moveTick && (r_fireCnt == FIRE_LAST) && !w_fatal;
  assign w_freeOH      = ~r_valid & (r_valid + NUM_BULLETS'(1));
  assign w_doSpawn     = w_fireAttempt && (|w_freeOH);

  always_comb begin
    w_xNext   = r_x;
    w_dirNext = r_state;
    if (X_MAX > 1) begin
      if (r_state == S_RIGHT) begin
        if (r_x == X_LAST) begin
          w_xNext   = r_x - X_W'(1);
          w_dirNext = S_LEFT;
        end else begin
          w_xNext = r_x + X_W'(1);
        end
      end else if (r_state == S_LEFT) begin
        if (r_x == '0) begin
          w_xNext   = X_W'(1);
          w_dirNext = S_RIGHT;
        end else begin
          w_xNext = r_x - X_W'(1);
        end
      end
    end
  end

  // A fatal hit on a move tick still moves x; the later DEAD assignment wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_RIGHT;
      r_x       <= '0;
      r_alive   <= 1'b1;
      r_health  <= HEALTH_FULL;
      r_fireCnt <= '0;
      r_fire    <= 1'b0;
      r_died    <= 1'b0;
    end else begin
      r_fire <= w_doSpawn;
      r_died <= w_fatal;
      if (respawn) begin
        r_state   <= S_RIGHT;
        r_x       <= '0;
        r_alive   <= 1'b1;
        r_health  <= HEALTH_FULL;
        r_fireCnt <= '0;
      end else if (r_state != S_DEAD) begin
        if (w_moveTick) begin
          r_x       <= w_xNext;
          r_state   <= w_dirNext;
          r_fireCnt <= (r_fireCnt == FIRE_LAST) ? '0 : r_fireCnt + FC_W'(1);
        end
        if (hit) begin
          r_health <= r_health - HEALTH_W'(1);
          if (w_fatal) begin
            r_alive <= 1'b0;
            r_state <= S_DEAD;
          end
        end
      end
    end
  end

  // Spawn targets a slot that was free at cycle start, so it never collides with advance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid   <= '0;
      r_bulletX <= '0;
      r_bulletY <= '0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (w_doSpawn && w_freeOH[i]) begin
          r_valid[i]               <= 1'b1;
          r_bulletX[i*X_W +: X_W]  <= r_x;
          r_bulletY[i*Y_W +: Y_W]  <= '0;
        end else if (w_bulletTick && r_valid[i]) begin
          if (r_bulletY[i*Y_W +: Y_W] == Y_LAST)
            r_valid[i] <= 1'b0;
          else
            r_bulletY[i*Y_W +: Y_W] <= r_bulletY[i*Y_W +: Y_W] + Y_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_enemy_shooter.sv
// Randomised and directed bench for enemy_shooter against a behavioural model
// built from enabled-cycle counts, a signed bounce direction and a bullet list.
module tb_enemy_shooter;

  localparam int XW = 8;
  localparam int YW = 8;
  localparam int XMAX = 4;
  localparam int YMAX = 5;
  localparam int MDIV = 2;
  localparam int BDIV = 3;
  localparam int FP = 2;
  localparam int NB = 2;
  localparam int HW = 3;
  localparam int HINIT = 3;

  logic clock = 1'b0;
  logic resetn;
  logic enable;
  logic hit;
  logic respawn;
  logic [XW-1:0] x;
  logic alive;
  logic [HW-1:0] health;
  logic [NB-1:0] bullet_valid;
  logic [NB*XW-1:0] bullet_x;
  logic [NB*YW-1:0] bullet_y;
  logic fire;
  logic died;

  enemy_shooter #(
    .X_W(XW), .Y_W(YW), .X_MAX(XMAX), .Y_MAX(YMAX), .MOVE_DIV(MDIV),
    .BULLET_DIV(BDIV), .FIRE_PERIOD(FP), .NUM_BULLETS(NB),
    .HEALTH_W(HW), .HEALTH_INIT(HINIT)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .hit(hit),
    .respawn(respawn), .x(x), .alive(alive), .health(health),
    .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .fire(fire), .died(died)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit checkEn = 0;

  int mx, mdir, mhealth, mfc, menc;
  bit malive, eFire, eDied;
  int bv[NB];
  int bx[NB];
  int by[NB];
  int ox, slot;
  bit mt, bt, fatal;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mx = 0; mdir = 1; malive = 1; mhealth = HINIT; mfc = 0; menc = 0;
    eFire = 0; eDied = 0;
    for (int i = 0; i < NB; i++) begin bv[i] = 0; bx[i] = 0; by[i] = 0; end
  endtask

  // Model: ticks derive from the number of enabled cycles since reset.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      resetModel();
    end else begin
      ox = mx; mt = 0; bt = 0; eFire = 0; eDied = 0; slot = -1;
      if (enable) begin
        menc++;
        mt = (menc % MDIV) == 0;
        bt = (menc % BDIV) == 0;
      end
      for (int i = 0; i < NB; i++) if (bv[i] == 0 && slot < 0) slot = i;
      if (bt)
        for (int i = 0; i < NB; i++)
          if (bv[i] != 0) begin
            if (by[i] == YMAX - 1) bv[i] = 0;
            else by[i]++;
          end
      if (respawn) begin
        mhealth = HINIT; malive = 1; mx = 0; mdir = 1; mfc = 0;
      end else if (malive) begin
        fatal = hit && (mhealth == 1);
        if (mt) begin
          if (XMAX > 1) begin
            if (mx + mdir < 0 || mx + mdir > XMAX - 1) mdir = -mdir;
            mx += mdir;
          end
          mfc++;
          if ((mfc % FP) == 0 && !fatal && slot >= 0) begin
            bv[slot] = 1; bx[slot] = ox; by[slot] = 0; eFire = 1;
          end
        end
        if (hit) begin
          mhealth--;
          if (mhealth == 0) begin malive = 0; eDied = 1; end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("x", 32'(x), mx);
      checkOutput("alive", 32'(alive), 32'(malive));
      checkOutput("health", 32'(health), mhealth);
      checkOutput("fire", 32'(fire), 32'(eFire));
      checkOutput("died", 32'(died), 32'(eDied));
      for (int i = 0; i < NB; i++) begin
        checkOutput("valid", 32'(bullet_valid[i]), bv[i]);
        checkOutput("bullet_x", 32'(bullet_x[i*XW +: XW]), bx[i]);
        checkOutput("bullet_y", 32'(bullet_y[i*YW +: YW]), by[i]);
      end
    end
  end

  task automatic applyStimulus(input bit en, input bit h, input bit r);
    @(negedge clock);
    enable = en; hit = h; respawn = r;
  endtask

  task automatic pulseHit(input int expHealth, input bit expDied);
    applyStimulus(enable, 1'b1, 1'b0);
    @(posedge clock); #1;
    checkOutput("hit_health", 32'(health), expHealth);
    checkOutput("hit_died", 32'(died), 32'(expDied));
    applyStimulus(enable, 1'b0, 1'b0);
  endtask

  int xSeq[7] = '{1, 2, 3, 2, 1, 0, 1};
  bit found;

  initial begin
    resetn = 1'b0; enable = 1'b0; hit = 1'b0; respawn = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("rst_x", 32'(x), 0);
    checkOutput("rst_health", 32'(health), 3);
    checkOutput("rst_alive", 32'(alive), 1);
    checkOutput("rst_valid", 32'(bullet_valid), 0);
    @(negedge clock);
    resetn = 1'b1; enable = 1'b1; checkEn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      repeat (2) @(posedge clock);
      #1;
      checkOutput("xseq", 32'(x), xSeq[i]);
      if (i == 1) begin
        checkOutput("fire_t2", 32'(fire), 1);
        checkOutput("slot0_x", 32'(bullet_x[XW-1:0]), 1);
      end
      if (i == 3) begin
        checkOutput("fire_t4", 32'(fire), 1);
        checkOutput("slot1_x", 32'(bullet_x[2*XW-1:XW]), 3);
        checkOutput("slot0_y", 32'(bullet_y[YW-1:0]), 1);
      end
      if (i == 5) begin
        checkOutput("fire_t6", 32'(fire), 0);
        checkOutput("pool_full", 32'(bullet_valid), 3);
      end
    end

    for (int c = 0; c < 500; c++)
      applyStimulus(($urandom % 8) != 0, ($urandom % 12) == 0, ($urandom % 30) == 0);

    @(negedge clock);
    enable = 1'b1; hit = 1'b0; respawn = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checkOutput("midrst_x", 32'(x), 0);
    checkOutput("midrst_valid", 32'(bullet_valid), 0);
    checkOutput("midrst_health", 32'(health), 3);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    pulseHit(2, 1'b0);
    pulseHit(1, 1'b0);
    pulseHit(0, 1'b1);
    pulseHit(0, 1'b0);
    repeat (40) applyStimulus(1'b1, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1);
    @(posedge clock); #1;
    checkOutput("hitresp_health", 32'(health), 3);
    checkOutput("hitresp_alive", 32'(alive), 1);
    checkOutput("hitresp_x", 32'(x), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    pulseHit(2, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    pulseHit(1, 1'b0);

    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clock);
      enable = 1'b1;
      if (malive && ((menc + 1) % MDIV) == 0 && ((mfc + 1) % FP) == 0) begin
        found = 1;
        hit = 1'b1;
        @(posedge clock); #1;
        checkOutput("fatal_fire", 32'(fire), 0);
        checkOutput("fatal_pool", 32'(bullet_valid), 0);
        checkOutput("fatal_died", 32'(died), 1);
        @(negedge clock);
        hit = 1'b0;
      end
    end
    checkOutput("fatal_found", 32'(found), 1);

    for (int c = 0; c < 2500; c++)
      applyStimulus(($urandom % 8) != 0, ($urandom % 12) == 0, ($urandom % 30) == 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_shooter.md
Name: enemy_shooter

Overview:
Second-generation enemy controller. It patrols one enemy ship horizontally, bouncing between the screen edges. It fires bullets from a fixed-depth pool at a programmable period, advances each live bullet down the screen until it expires, and tracks enemy health against hit pulses. The block sits between the game-top rate logic and the VGA draw/collision stage, replacing the fixed-width single-bullet handler with a parametrised, multi-bullet, health-aware one.

Parameters:
X_W, 8, width of x coordinates
Y_W, 8, width of y coordinates
X_MAX, 160, screen width; enemy x range is 0..X_MAX-1
Y_MAX, 120, screen height; bullet y range is 0..Y_MAX-1
MOVE_DIV, 12500000, clock cycles per move tick (>=1)
BULLET_DIV, 6250000, clock cycles per bullet tick (>=1)
FIRE_PERIOD, 4, move ticks between fire attempts (>=1)
NUM_BULLETS, 4, bullet pool depth (>=1)
HEALTH_W, 3, health counter width
HEALTH_INIT, 3, health after reset/respawn (>=1, <2^HEALTH_W)

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous, active-low reset
enable  in  1  high = tick counters run; low = counters hold
hit  in  1  one-cycle pulse: enemy was struck
respawn  in  1  one-cycle pulse: revive the enemy
x  out  X_W  enemy x position
alive  out  1  enemy alive
health  out  HEALTH_W  remaining health
bullet_valid  out  NUM_BULLETS  per-slot live flag
bullet_x  out  NUM_BULLETS*X_W  slot i at [i*X_W +: X_W]
bullet_y  out  NUM_BULLETS*Y_W  slot i at [i*Y_W +: Y_W]
fire  out  1  one-cycle pulse when a bullet spawns
died  out  1  one-cycle pulse on the cycle health reaches 0

Behaviour:
- Reset (async assert, sync deassert by the top level):
  - Control state: x=0, dir=RIGHT, alive=1, health=HEALTH_INIT.
  - Bullets: all bullet_valid=0, all bullet_x/y=0.
  - Pulses and counters: fire=0, died=0, move_cnt=MOVE_DIV-1, bul_cnt=BULLET_DIV-1, fire_cnt=0.
- Tick generators:
  - move_cnt counts down only while enable=1.
  - move_tick is asserted for one cycle when move_cnt==0 and enable=1; move_cnt then reloads to MOVE_DIV-1.
  - bullet_tick is generated the same way from bul_cnt and BULLET_DIV.
  - Both ticks are internal and synchronous; nothing is clocked off a derived clock.
- Movement FSM (states RIGHT, LEFT, DEAD), updated on move_tick only:
  - RIGHT: if x==X_MAX-1, go to LEFT and set x=x-1; else x=x+1.
  - LEFT: if x==0, go to RIGHT and set x=1; else x=x-1.
  - No overshoot: x never leaves 0..X_MAX-1. X_MAX==1 holds x at 0.
  - DEAD: x frozen, no fire attempts.
- Fire:
  - On a move_tick while alive, fire_cnt increments.
  - When fire_cnt==FIRE_PERIOD-1, fire_cnt resets to 0 and a spawn is attempted.
  - The spawn takes the lowest-index slot whose bullet_valid was 0 at the start of the cycle.
  - That slot gets valid=1, bullet_x=x (pre-update value this cycle), bullet_y=0, and fire pulses.
  - If no slot is free, the shot is dropped, fire stays 0, and fire_cnt still resets.
- Bullet advance, on bullet_tick, for each valid slot:
  - If y==Y_MAX-1: valid=0 (expired); x/y hold their last values.
  - Else: y=y+1.
  - A slot spawning this cycle is not advanced.
  - A slot freed this cycle is not reusable until the next cycle.
- Health:
  - On hit while alive: health=health-1.
  - If health was 1: health=0, alive=0, state goes to DEAD, died pulses.
  - If a move_tick coincides with the fatal hit, that tick's x update still occurs but its fire attempt is suppressed.
  - hit while dead is ignored.
  - hit is sampled regardless of enable.
- Respawn (any state, priority over hit in the same cycle):
  - Sets health=HEALTH_INIT, alive=1, x=0, dir=RIGHT, fire_cnt=0.
  - Leaves tick counters and in-flight bullets untouched.
- Bullets keep advancing and expiring after the enemy dies.
- All outputs are registered; fire and died are high for exactly one cycle.

Test Plan:
- Reset mid-operation: MOVE_DIV=2, X_MAX=4, enable=1; deassert resetn asynchronously during motion -> x=0, bullet_valid=0, health=3 immediately; after release, x sequence per move tick is 1,2,3,2,1,0,1.
- Fire cadence and pool: FIRE_PERIOD=2, NUM_BULLETS=2, BULLET_DIV large -> fire on move ticks 2 and 4 fills slots 0 and 1; tick 6 produces no fire pulse and bullet_valid stays 2'b11.
- Bullet expiry and slot reuse: Y_MAX=3, BULLET_DIV=1 -> slot 0 y goes 0,1,2, then valid drops; the next fire attempt reuses slot 0 with bullet_x equal to x at spawn.
- Health: HEALTH_INIT=3, three hit pulses -> health 2,1,0; died pulses once on the third; a fourth hit leaves health=0; x freezes and fire stays 0 while bullets continue to advance.
- Simultaneous events: hit and respawn in the same cycle while dead -> health=3, alive=1, x=0; a fatal hit coinciding with a move_tick at fire_cnt==FIRE_PERIOD-1 -> no spawn.
- Enable hold: enable=0 for 10 cycles mid-count -> x, bullet_y and the counters are unchanged; a hit in that window still decrements health.
